// File: rtl/peripheral_arbiter.sv
// Two-slot request arbiter in front of peripheral_master: one-entry slot per requester,
// one transaction in flight, VALID pulse on issue, response routed back to the owning slot.
`timescale 1ns/1ps
module peripheral_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  input  logic        REQ0_VALID,
  input  logic [63:0] REQ0_ADDR,
  input  logic [63:0] REQ0_WDATA,
  input  logic [7:0]  REQ0_WSTRB,
  input  logic        REQ0_WRITE,
  input  logic        REQ0_WORD,
  output logic        REQ0_BUSY,
  output logic        RESP0_VALID,
  output logic [63:0] RESP0_DATA,
  input  logic        REQ1_VALID,
  input  logic [63:0] REQ1_ADDR,
  input  logic [63:0] REQ1_WDATA,
  input  logic [7:0]  REQ1_WSTRB,
  input  logic        REQ1_WRITE,
  input  logic        REQ1_WORD,
  output logic        REQ1_BUSY,
  output logic        RESP1_VALID,
  output logic [63:0] RESP1_DATA,
  output logic        ADDR_TO_PERI_VALID,
  output logic [63:0] ADDR_TO_PERI,
  output logic [63:0] DATA_TO_PERI,
  output logic [7:0]  WSTRB,
  output logic        WRITE_TO_PERI,
  output logic        PERI_WORD_ACCESS,
  input  logic        DATA_FROM_PERI_READY,
  input  logic [63:0] DATA_FROM_PERI,
  output logic        GRANT_OWNER
);
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_grant;
  logic                   w_done;
  logic                   w_winner;

  logic [1:0]             w_req_valid;
  logic [1:0]             w_req_write;
  logic [1:0]             w_req_word;
  logic [1:0][DATA_W-1:0] w_req_addr;
  logic [1:0][DATA_W-1:0] w_req_wdata;
  logic [1:0][STRB_W-1:0] w_req_wstrb;
  logic [1:0]             w_cap;
  logic [1:0]             w_clr;

  logic [1:0]             r_pend;
  logic [1:0]             r_slot_write;
  logic [1:0]             r_slot_word;
  logic [1:0][DATA_W-1:0] r_slot_addr;
  logic [1:0][DATA_W-1:0] r_slot_wdata;
  logic [1:0][STRB_W-1:0] r_slot_wstrb;

  logic                   r_last;
  logic                   r_owner;
  logic                   r_peri_valid;
  logic [DATA_W-1:0]      r_peri_addr;
  logic [DATA_W-1:0]      r_peri_wdata;
  logic [STRB_W-1:0]      r_peri_wstrb;
  logic                   r_peri_write;
  logic                   r_peri_word;
  logic [1:0]             r_resp_valid;
  logic [1:0][DATA_W-1:0] r_resp_data;

  assign w_req_valid = {REQ1_VALID, REQ0_VALID};
  assign w_req_write = {REQ1_WRITE, REQ0_WRITE};
  assign w_req_word  = {REQ1_WORD,  REQ0_WORD};
  assign w_req_addr  = {REQ1_ADDR,  REQ0_ADDR};
  assign w_req_wdata = {REQ1_WDATA, REQ0_WDATA};
  assign w_req_wstrb = {REQ1_WSTRB, REQ0_WSTRB};

  // A pulse is taken only into an empty slot; completion frees the owner's slot.
  assign w_cap = w_req_valid & ~r_pend;
  assign w_clr = w_done ? (2'b01 << r_owner) : 2'b00;

  // Winner selection: round-robin prefers the slot that did not complete last.
  always_comb begin
    w_winner = 1'b0;
    if (PRIO_MODE == 1) begin
      w_winner = ~r_pend[0];
    end else if (r_pend[~r_last]) begin
      w_winner = ~r_last;
    end else begin
      w_winner = r_last;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // READY is only honoured in WAIT, so an early READY during ISSUE is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (DATA_FROM_PERI_READY) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_pend <= 2'b00;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_cap;
    end
  end

  // Slot payload is qualified by r_pend, so it needs no reset.
  always_ff @(posedge M_AXI_ACLK) begin
    for (int n = 0; n < 2; n++) begin
      if (w_cap[n]) begin
        r_slot_addr[n]  <= w_req_addr[n];
        r_slot_wdata[n] <= w_req_wdata[n];
        r_slot_wstrb[n] <= w_req_wstrb[n];
        r_slot_write[n] <= w_req_write[n];
        r_slot_word[n]  <= w_req_word[n];
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_peri_valid <= 1'b0;
      r_owner      <= 1'b0;
      r_peri_addr  <= '0;
      r_peri_wdata <= '0;
      r_peri_wstrb <= '0;
      r_peri_write <= 1'b0;
      r_peri_word  <= 1'b0;
    end else begin
      r_peri_valid <= w_grant;
      if (w_grant) begin
        r_owner      <= w_winner;
        r_peri_addr  <= r_slot_addr[w_winner];
        r_peri_wdata <= r_slot_wdata[w_winner];
        r_peri_wstrb <= r_slot_wstrb[w_winner];
        r_peri_write <= r_slot_write[w_winner];
        r_peri_word  <= r_slot_word[w_winner];
      end
    end
  end

  // last_grant resets to 1 so slot 0 wins the first tie after reset.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_resp_valid <= 2'b00;
      r_resp_data  <= '0;
      r_last       <= 1'b1;
    end else begin
      r_resp_valid <= w_clr;
      if (w_done) begin
        r_resp_data[r_owner] <= DATA_FROM_PERI;
        r_last               <= r_owner;
      end
    end
  end

  assign REQ0_BUSY          = r_pend[0];
  assign REQ1_BUSY          = r_pend[1];
  assign RESP0_VALID        = r_resp_valid[0];
  assign RESP1_VALID        = r_resp_valid[1];
  assign RESP0_DATA         = r_resp_data[0];
  assign RESP1_DATA         = r_resp_data[1];
  assign ADDR_TO_PERI_VALID = r_peri_valid;
  assign ADDR_TO_PERI       = r_peri_addr;
  assign DATA_TO_PERI       = r_peri_wdata;
  assign WSTRB              = r_peri_wstrb;
  assign WRITE_TO_PERI      = r_peri_write;
  assign PERI_WORD_ACCESS   = r_peri_word;
  assign GRANT_OWNER        = r_owner;

endmodule

// File: tb/tb_peripheral_arbiter.sv
// Bench for peripheral_arbiter: instance 0 round-robin, instance 1 fixed priority,
// a two-cycle master model per instance, and a scoreboard of expected issues/responses.
`timescale 1ns/1ps
module tb_peripheral_arbiter;
  typedef struct {
    int          d;
    int          own;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wr;
    logic        wd;
    logic [63:0] rdata;
    int          t_issue;
    int          t_resp;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][1:0]       rq_v, rq_wr, rq_wd, busy, rsp_v;
  logic [1:0][1:0][63:0] rq_addr, rq_wdata, rsp_data;
  logic [1:0][1:0][7:0]  rq_wstrb;
  logic [1:0]            m_v, m_wr, m_wd, m_rdy, gown;
  logic [1:0][63:0]      m_addr, m_wdata, m_rdata;
  logic [1:0][7:0]       m_wstrb;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    peripheral_arbiter #(.PRIO_MODE(g)) u_dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .REQ0_VALID(rq_v[g][0]), .REQ0_ADDR(rq_addr[g][0]), .REQ0_WDATA(rq_wdata[g][0]),
      .REQ0_WSTRB(rq_wstrb[g][0]), .REQ0_WRITE(rq_wr[g][0]), .REQ0_WORD(rq_wd[g][0]),
      .REQ0_BUSY(busy[g][0]), .RESP0_VALID(rsp_v[g][0]), .RESP0_DATA(rsp_data[g][0]),
      .REQ1_VALID(rq_v[g][1]), .REQ1_ADDR(rq_addr[g][1]), .REQ1_WDATA(rq_wdata[g][1]),
      .REQ1_WSTRB(rq_wstrb[g][1]), .REQ1_WRITE(rq_wr[g][1]), .REQ1_WORD(rq_wd[g][1]),
      .REQ1_BUSY(busy[g][1]), .RESP1_VALID(rsp_v[g][1]), .RESP1_DATA(rsp_data[g][1]),
      .ADDR_TO_PERI_VALID(m_v[g]), .ADDR_TO_PERI(m_addr[g]), .DATA_TO_PERI(m_wdata[g]),
      .WSTRB(m_wstrb[g]), .WRITE_TO_PERI(m_wr[g]), .PERI_WORD_ACCESS(m_wd[g]),
      .DATA_FROM_PERI_READY(m_rdy[g]), .DATA_FROM_PERI(m_rdata[g]),
      .GRANT_OWNER(gown[g])
    );
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   cd [2];
  ent_t cur [2];
  ent_t iq [$];
  ent_t rq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int d, input int own, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] wstrb,
                               input logic wr, input logic wd, input logic [63:0] rdata,
                               input int ti, input int tr);
    ent_t e;
    e.d = d; e.own = own; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
    e.wr = wr; e.wd = wd; e.rdata = rdata; e.t_issue = ti; e.t_resp = tr;
    iq.push_back(e);
  endfunction

  task automatic drive(input int d, input int s, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wstrb, input logic wr, input logic wd);
    rq_v[d][s]     = 1'b1;
    rq_addr[d][s]  = addr;
    rq_wdata[d][s] = wdata;
    rq_wstrb[d][s] = wstrb;
    rq_wr[d][s]    = wr;
    rq_wd[d][s]    = wd;
  endtask

  // One clock: master model answers READY two cycles after VALID; scoreboard checks issue and response.
  task automatic tick();
    int   idx;
    ent_t e;
    @(posedge clk);
    #1;
    cyc++;
    rq_v = '0;
    for (int d = 0; d < 2; d++) begin
      m_rdy[d] = 1'b0;
      if (cd[d] > 0) begin
        chk($sformatf("d%0d_valid_single", d), 64'(m_v[d]), '0);
        chk($sformatf("d%0d_hold_addr", d), m_addr[d], cur[d].addr);
        chk($sformatf("d%0d_hold_wdata", d), m_wdata[d], cur[d].wdata);
        chk($sformatf("d%0d_hold_wstrb", d), 64'(m_wstrb[d]), 64'(cur[d].wstrb));
        chk($sformatf("d%0d_hold_ctl", d), 64'({gown[d], m_wr[d], m_wd[d]}),
            64'({1'(cur[d].own), cur[d].wr, cur[d].wd}));
        cd[d]--;
        if (cd[d] == 0) begin
          m_rdy[d]   = 1'b1;
          m_rdata[d] = cur[d].rdata;
          rq.push_back(cur[d]);
        end
      end else if (m_v[d]) begin
        idx = -1;
        for (int i = 0; i < iq.size(); i++) if (idx < 0 && iq[i].d == d) idx = i;
        if (idx < 0) begin
          chk($sformatf("d%0d_unexpected_valid", d), 64'(m_v[d]), '0);
        end else begin
          e = iq[idx];
          iq.delete(idx);
          chk($sformatf("d%0d_issue_owner", d), 64'(gown[d]), 64'(e.own));
          chk($sformatf("d%0d_issue_addr", d), m_addr[d], e.addr);
          chk($sformatf("d%0d_issue_wdata", d), m_wdata[d], e.wdata);
          chk($sformatf("d%0d_issue_wstrb", d), 64'(m_wstrb[d]), 64'(e.wstrb));
          chk($sformatf("d%0d_issue_wr_word", d), 64'({m_wr[d], m_wd[d]}), 64'({e.wr, e.wd}));
          chk($sformatf("d%0d_issue_cycle", d), 64'(cyc), 64'(e.t_issue));
          cur[d] = e;
          cd[d]  = 2;
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (rsp_v[d][s]) begin
          idx = -1;
          for (int i = 0; i < rq.size(); i++) if (idx < 0 && rq[i].d == d && rq[i].own == s) idx = i;
          if (idx < 0) begin
            chk($sformatf("d%0d_unexpected_resp%0d", d, s), 64'(rsp_v[d][s]), '0);
          end else begin
            e = rq[idx];
            rq.delete(idx);
            chk($sformatf("d%0d_resp%0d_data", d, s), rsp_data[d][s], e.rdata);
            chk($sformatf("d%0d_resp%0d_cycle", d, s), 64'(cyc), 64'(e.t_resp));
            chk($sformatf("d%0d_resp%0d_busy", d, s), 64'(busy[d][s]), '0);
          end
        end
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((iq.size() != 0 || rq.size() != 0 || cd[0] != 0 || cd[1] != 0) && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_issue_queue", 64'(iq.size()), '0);
    chk("drain_resp_queue", 64'(rq.size()), '0);
    tick();
  endtask

  task automatic chk_zero(input int d);
    chk($sformatf("d%0d_zero_mvalid", d), 64'(m_v[d]), '0);
    chk($sformatf("d%0d_zero_maddr", d), m_addr[d], '0);
    chk($sformatf("d%0d_zero_mwdata", d), m_wdata[d], '0);
    chk($sformatf("d%0d_zero_ctl", d), 64'({m_wstrb[d], m_wr[d], m_wd[d], gown[d]}), '0);
    chk($sformatf("d%0d_zero_busy_resp", d), 64'({busy[d], rsp_v[d]}), '0);
    chk($sformatf("d%0d_zero_resp0_data", d), rsp_data[d][0], '0);
    chk($sformatf("d%0d_zero_resp1_data", d), rsp_data[d][1], '0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    cd[0] = 0;
    cd[1] = 0;
    m_rdy = '0;
    iq.delete();
    rq.delete();
    tick();
    rst = 1'b0;
    chk_zero(0);
    chk_zero(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    rq_v = '0; rq_wr = '0; rq_wd = '0;
    rq_addr = '0; rq_wdata = '0; rq_wstrb = '0;
    m_rdy = '0; m_rdata = '0;
    cd[0] = 0;
    cd[1] = 0;
    repeat (2) tick();
    do_reset();

    // Single CLINT mtime read on slot 0.
    t = cyc;
    drive(0, 0, 64'h200BFF8, 64'h0, 8'h00, 1'b0, 1'b0);
    push(0, 0, 64'h200BFF8, 64'h0, 8'h00, 1'b0, 1'b0, 64'h1234, t + 2, t + 5);
    tick();
    chk("single_busy0", 64'(busy[0][0]), 64'd1);
    drain(40);
    chk("resp0_data_held", rsp_data[0][0], 64'h1234);

    // Simultaneous pair after reset, twice: round-robin order 0,1 then 0,1.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      t = cyc;
      drive(0, 0, 64'h2000100 + 64'(k), 64'h0, 8'h0F, 1'b0, 1'b1);
      drive(0, 1, 64'h2000200 + 64'(k), 64'h0, 8'h0F, 1'b0, 1'b1);
      push(0, 0, 64'h2000100 + 64'(k), 64'h0, 8'h0F, 1'b0, 1'b1, 64'hA0 + 64'(k), t + 2, t + 5);
      push(0, 1, 64'h2000200 + 64'(k), 64'h0, 8'h0F, 1'b0, 1'b1, 64'hB0 + 64'(k), t + 6, t + 9);
      tick();
      chk("pair_busy", 64'(busy[0]), 64'd3);
      drain(40);
    end

    // Write from slot 1; hold of master-side fields is checked every WAIT cycle.
    t = cyc;
    drive(0, 1, 64'h2004000, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1, 1'b0);
    push(0, 1, 64'h2004000, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1, 1'b0, 64'h5A, t + 2, t + 5);
    drain(40);

    // Slot 0 waits behind slot 1 and is re-pulsed while busy; the first address must win.
    t = cyc;
    drive(0, 1, 64'h2000300, 64'h0, 8'h00, 1'b0, 1'b0);
    push(0, 1, 64'h2000300, 64'h0, 8'h00, 1'b0, 1'b0, 64'h31, t + 2, t + 5);
    tick();
    drive(0, 0, 64'h2000400, 64'h1111, 8'h03, 1'b1, 1'b1);
    push(0, 0, 64'h2000400, 64'h1111, 8'h03, 1'b1, 1'b1, 64'h41, t + 6, t + 9);
    tick();
    chk("repulse_busy0", 64'(busy[0][0]), 64'd1);
    tick();
    drive(0, 0, 64'h2000800, 64'h2222, 8'hF0, 1'b0, 1'b0);
    drain(40);

    // Slot 0 re-requests in its RESP cycle together with slot 1: fixed serves 0 again, RR serves 1.
    do_reset();
    t = cyc;
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 64'h2000500, 64'h0, 8'h00, 1'b0, 1'b0);
      push(d, 0, 64'h2000500, 64'h0, 8'h00, 1'b0, 1'b0, 64'h50, t + 2, t + 5);
    end
    repeat (5) tick();
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 64'h2000600, 64'h0, 8'h00, 1'b0, 1'b0);
      drive(d, 1, 64'h2000700, 64'h0, 8'h00, 1'b0, 1'b0);
    end
    push(1, 0, 64'h2000600, 64'h0, 8'h00, 1'b0, 1'b0, 64'h60, t + 7, t + 10);
    push(1, 1, 64'h2000700, 64'h0, 8'h00, 1'b0, 1'b0, 64'h70, t + 11, t + 14);
    push(0, 1, 64'h2000700, 64'h0, 8'h00, 1'b0, 1'b0, 64'h71, t + 7, t + 10);
    push(0, 0, 64'h2000600, 64'h0, 8'h00, 1'b0, 1'b0, 64'h61, t + 11, t + 14);
    drain(60);

    // Reset in WAIT: no response pulse, everything back to zero, then a clean transaction.
    t = cyc;
    drive(0, 0, 64'h2000900, 64'h0, 8'h00, 1'b0, 1'b0);
    push(0, 0, 64'h2000900, 64'h0, 8'h00, 1'b0, 1'b0, 64'h90, t + 2, t + 5);
    repeat (3) tick();
    do_reset();
    repeat (3) tick();
    t = cyc;
    drive(0, 0, 64'h2000A00, 64'h0, 8'h00, 1'b0, 1'b1);
    push(0, 0, 64'h2000A00, 64'h0, 8'h00, 1'b0, 1'b1, 64'hA00, t + 2, t + 5);
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
